// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Serves single-cycle word hits and moves 128-bit blocks to and from data_memory on a miss.
module data_cache #(
  parameter int NUM_SETS = 8,
  parameter int TAG_W    = 28 - $clog2(NUM_SETS)
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         CPU_READ,
  input  logic         CPU_WRITE,
  input  logic [31:0]  CPU_ADDRESS,
  input  logic [3:0]   CPU_BYTE_EN,
  input  logic [31:0]  CPU_WRITE_DATA,
  output logic [31:0]  CPU_READ_DATA,
  output logic         CPU_BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITE_DATA,
  input  logic [127:0] MEM_READ_DATA,
  input  logic         MEM_BUSYWAIT
);

  localparam int IW = $clog2(NUM_SETS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE_BACK,
    ST_ALLOCATE,
    ST_UPDATE
  } state_t;

  state_t r_state, w_next_state;

  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [127:0]        r_data [NUM_SETS];

  logic [IW-1:0]    w_index;
  logic [TAG_W-1:0] w_tag;
  logic [1:0]       w_offset;
  logic             w_req;
  logic             w_hit;
  logic             w_write_hit;
  logic [31:0]      w_word;
  logic [31:0]      w_merged;
  logic             w_unused;

  assign w_index  = CPU_ADDRESS[4+IW-1:4];
  assign w_tag    = CPU_ADDRESS[31:4+IW];
  assign w_offset = CPU_ADDRESS[3:2];
  assign w_unused = &{1'b0, CPU_ADDRESS[1:0]};

  assign w_req       = CPU_READ | CPU_WRITE;
  assign w_hit       = r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_write_hit = (r_state == ST_IDLE) & CPU_WRITE & w_hit;
  assign w_word      = r_data[w_index][32*w_offset +: 32];

  always_comb begin
    w_merged = w_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (CPU_BYTE_EN[b]) w_merged[8*b +: 8] = CPU_WRITE_DATA[8*b +: 8];
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_UPDATE) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end else if (w_write_hit) begin
        r_dirty[w_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits alone decide whether contents are used.
  always_ff @(posedge CLOCK) begin
    if (r_state == ST_UPDATE) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= MEM_READ_DATA;
    end else if (w_write_hit) begin
      r_data[w_index][32*w_offset +: 32] <= w_merged;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    CPU_BUSYWAIT   = 1'b1;
    CPU_READ_DATA  = '0;
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b0;
    MEM_ADDRESS    = '0;
    MEM_WRITE_DATA = '0;
    case (r_state)
      ST_IDLE: begin
        CPU_BUSYWAIT = w_req & ~w_hit;
        if (CPU_READ && w_hit) CPU_READ_DATA = w_word;
        if (w_req && !w_hit)
          w_next_state = (r_valid[w_index] & r_dirty[w_index]) ? ST_WRITE_BACK : ST_ALLOCATE;
      end
      ST_WRITE_BACK: begin
        MEM_WRITE      = 1'b1;
        MEM_ADDRESS    = {r_tag[w_index], w_index};
        MEM_WRITE_DATA = r_data[w_index];
        if (!MEM_BUSYWAIT) w_next_state = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = CPU_ADDRESS[31:4];
        if (!MEM_BUSYWAIT) w_next_state = ST_UPDATE;
      end
      ST_UPDATE: begin
        MEM_ADDRESS  = CPU_ADDRESS[31:4];
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a 16-beat block memory model behind it.
module tb_data_cache;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b0;
  logic         CPU_READ = 1'b0;
  logic         CPU_WRITE = 1'b0;
  logic [31:0]  CPU_ADDRESS = '0;
  logic [3:0]   CPU_BYTE_EN = '0;
  logic [31:0]  CPU_WRITE_DATA = '0;
  logic [31:0]  CPU_READ_DATA;
  logic         CPU_BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITE_DATA;
  logic [127:0] MEM_READ_DATA;
  logic         MEM_BUSYWAIT;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  data_cache #(.NUM_SETS(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .CPU_READ(CPU_READ), .CPU_WRITE(CPU_WRITE), .CPU_ADDRESS(CPU_ADDRESS),
    .CPU_BYTE_EN(CPU_BYTE_EN), .CPU_WRITE_DATA(CPU_WRITE_DATA),
    .CPU_READ_DATA(CPU_READ_DATA), .CPU_BUSYWAIT(CPU_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITE_DATA(MEM_WRITE_DATA), .MEM_READ_DATA(MEM_READ_DATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLOCK = ~CLOCK;

  // Block memory: byte k of block b is b*16+k, except block 1 which holds bytes 0..15.
  logic [127:0] mem [16];
  logic [3:0]   beat = '0;
  logic [127:0] rd_latch = '0;

  initial begin
    for (int b = 0; b < 16; b++)
      for (int k = 0; k < 16; k++)
        mem[b][8*k +: 8] = (b == 1) ? 8'(k) : 8'(b*16 + k);
  end

  assign MEM_BUSYWAIT  = (MEM_READ | MEM_WRITE) && (beat != 4'd15);
  assign MEM_READ_DATA = rd_latch;

  always @(posedge CLOCK) begin
    if (!(MEM_READ || MEM_WRITE)) begin
      beat <= '0;
    end else if (beat == 4'd15) begin
      beat <= '0;
      if (MEM_WRITE) mem[MEM_ADDRESS[3:0]] <= MEM_WRITE_DATA;
      if (MEM_READ)  rd_latch <= mem[MEM_ADDRESS[3:0]];
    end else begin
      beat <= beat + 4'd1;
    end
  end

  int unsigned both_en = 0;
  always @(negedge CLOCK) if (MEM_READ && MEM_WRITE) both_en++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    @(posedge CLOCK); #1;
    CPU_READ = rd; CPU_WRITE = wr; CPU_ADDRESS = addr;
    CPU_BYTE_EN = be; CPU_WRITE_DATA = wdata;
  endtask

  task automatic release_req();
    @(posedge CLOCK); #1;
    CPU_READ = 1'b0; CPU_WRITE = 1'b0;
  endtask

  // Counts stall cycles and memory beats until CPU_BUSYWAIT drops, then samples the read word.
  task automatic measure(output int stalls, output int nrd, output int nwr,
                         output logic [27:0] rd_addr, output logic [27:0] wr_addr,
                         output logic [127:0] wblk, output logic [31:0] rdata);
    bit done = 0;
    stalls = 0; nrd = 0; nwr = 0; rd_addr = '0; wr_addr = '0; wblk = '0; rdata = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLOCK);
      if (!CPU_BUSYWAIT) begin done = 1; break; end
      stalls++;
      if (MEM_READ)  begin nrd++; rd_addr = MEM_ADDRESS; end
      if (MEM_WRITE) begin nwr++; wr_addr = MEM_ADDRESS; wblk = MEM_WRITE_DATA; end
    end
    if (!done) check("busywait_timeout", 128'(CPU_BUSYWAIT), 128'(0));
    rdata = CPU_READ_DATA;
  endtask

  int           st, nr, nw;
  logic [27:0]  ra, wa;
  logic [127:0] wb;
  logic [31:0]  rd;

  initial begin
    // Reset state, idle and with a pending read.
    #12;
    check("rst_busy_idle", 128'(CPU_BUSYWAIT), 128'(0));
    check("rst_mem_read", 128'(MEM_READ), 128'(0));
    check("rst_mem_write", 128'(MEM_WRITE), 128'(0));
    check("rst_mem_addr", 128'(MEM_ADDRESS), 128'(0));
    check("rst_mem_wdata", MEM_WRITE_DATA, 128'(0));
    CPU_READ = 1'b1; CPU_ADDRESS = 32'h10; #1;
    check("rst_busy_req", 128'(CPU_BUSYWAIT), 128'(1));
    check("rst_rdata", 128'(CPU_READ_DATA), 128'(0));
    CPU_READ = 1'b0;
    @(negedge CLOCK); RESET = 1'b1;

    // Clean miss fill of block 1.
    drive(1, 0, 32'h10, 4'h0, 32'h0);
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("miss_stalls", 128'(st), 128'(18));
    check("miss_reads", 128'(nr), 128'(16));
    check("miss_writes", 128'(nw), 128'(0));
    check("miss_raddr", 128'(ra), 128'(28'h1));
    check("miss_rdata", 128'(rd), 128'(32'h03020100));

    // Read hit on the neighbouring word.
    drive(1, 0, 32'h14, 4'h0, 32'h0);
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("hit_stalls", 128'(st), 128'(0));
    check("hit_reads", 128'(nr), 128'(0));
    check("hit_rdata", 128'(rd), 128'(32'h07060504));

    // Partial-byte write hit, then read back.
    drive(0, 1, 32'h10, 4'b0011, 32'hDEADBEEF);
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("whit_stalls", 128'(st), 128'(0));
    drive(1, 0, 32'h10, 4'h0, 32'h0);
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("whit_readback", 128'(rd), 128'(32'h0302BEEF));

    // Dirty eviction of line 1 by block 9.
    drive(1, 0, 32'h90, 4'h0, 32'h0);
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("dirty_stalls", 128'(st), 128'(34));
    check("dirty_writes", 128'(nw), 128'(16));
    check("dirty_waddr", 128'(wa), 128'(28'h1));
    check("dirty_wword0", 128'(wb[31:0]), 128'(32'h0302BEEF));
    check("dirty_reads", 128'(nr), 128'(16));
    check("dirty_raddr", 128'(ra), 128'(28'h9));
    check("dirty_rdata", 128'(rd), 128'(32'h93929190));
    check("mem_blk1_word0", 128'(mem[1][31:0]), 128'(32'h0302BEEF));

    // Reset during ALLOCATE abandons the fill; the held read misses again in full.
    drive(1, 0, 32'h20, 4'h0, 32'h0);
    for (int c = 0; c < 5; c++) @(negedge CLOCK);
    check("mid_mem_read_pre", 128'(MEM_READ), 128'(1));
    RESET = 1'b0; #1;
    check("mid_mem_read", 128'(MEM_READ), 128'(0));
    check("mid_mem_addr", 128'(MEM_ADDRESS), 128'(0));
    check("mid_busy", 128'(CPU_BUSYWAIT), 128'(1));
    @(posedge CLOCK); #1; RESET = 1'b1;
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("mid_retry_stalls", 128'(st), 128'(18));
    check("mid_retry_rdata", 128'(rd), 128'(32'h23222120));

    // Simultaneous read and write on a hit is a write.
    drive(1, 1, 32'h24, 4'hF, 32'hCAFEF00D);
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("rw_stalls", 128'(st), 128'(0));
    drive(1, 0, 32'h24, 4'h0, 32'h0);
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("rw_readback", 128'(rd), 128'(32'hCAFEF00D));
    drive(1, 0, 32'hA4, 4'h0, 32'h0);
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("rw_dirty_stalls", 128'(st), 128'(34));
    check("rw_dirty_wword1", 128'(wb[63:32]), 128'(32'hCAFEF00D));
    check("rw_dirty_waddr", 128'(wa), 128'(28'h2));
    check("rw_dirty_rdata", 128'(rd), 128'(32'hA7A6A5A4));

    // Index wrap: 0x000 and 0x080 share line 0 and evict each other.
    drive(1, 0, 32'h000, 4'h0, 32'h0);
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("wrap_a_stalls", 128'(st), 128'(18));
    check("wrap_a_rdata", 128'(rd), 128'(32'h03020100));
    drive(1, 0, 32'h080, 4'h0, 32'h0);
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("wrap_b_stalls", 128'(st), 128'(18));
    check("wrap_b_rdata", 128'(rd), 128'(32'h83828180));
    drive(1, 0, 32'h000, 4'h0, 32'h0);
    measure(st, nr, nw, ra, wa, wb, rd);
    release_req();
    check("wrap_a2_stalls", 128'(st), 128'(18));

    check("mem_enables_exclusive", 128'(both_en), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
